fetch_queue: RTL and testbench

Parametrised fetch stage replacing the fixed single-register PC-plus-pipeline-latch fetch. It owns the fetch PC and issues in-order requests to an instruction memory with variable latency. Returned instructions are buffered in a DEPTH-entry queue that feeds decode through a valid/ready handshake. Branch/jump redirects from execute flush the queue and discard responses still in flight.

---
 rtl/fetch_queue.sv | 131 +++++++++++++
 tb/tb_fetch_queue.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC owner, in-order instruction-memory requester with a
// PC-tag FIFO, and a DEPTH-entry instruction queue feeding decode.
// Redirects flush the queue and drop responses still in flight.
// Optional build macro FETCH_QUEUE_BYPASS_EN: an empty queue forwards a
// returning instruction straight to decode in the same cycle.
module fetch_queue #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             dec_valid,
    output logic [WIDTH-1:0] dec_instr,
    output logic [WIDTH-1:0] dec_pc,
    output logic [WIDTH-1:0] dec_pcplus4,
    input  logic             dec_ready
);
    localparam int unsigned   PW         = $clog2(DEPTH);
    localparam int unsigned   CW         = $clog2(DEPTH + 1);
    localparam logic [CW:0]   FULL_LEVEL = (CW + 1)'(DEPTH);

    logic [WIDTH-1:0] fetchPc;
    logic [CW-1:0]    count;
    logic [CW-1:0]    outstanding;
    logic [CW-1:0]    discard;
    logic [PW-1:0]    rdPtr;
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    tagRdPtr;
    logic [PW-1:0]    tagWrPtr;

    logic [WIDTH-1:0] instrMem [DEPTH];
    logic [WIDTH-1:0] pcMem    [DEPTH];
    logic [WIDTH-1:0] tagMem   [DEPTH];

    logic             grant;
    logic             respValid;
    logic             respKeep;
    logic             bypassHit;
    logic             push;
    logic             pop;
    logic [CW:0]      inUse;

    // Queue slots plus requests in flight never exceed DEPTH, so every
    // granted request already owns a queue slot and a tag slot.
    assign inUse     = {1'b0, count} + {1'b0, outstanding};
    assign imem_req  = rst && !redirect && (inUse < FULL_LEVEL);
    assign imem_addr = fetchPc;
    assign grant     = imem_req && imem_gnt;

    // A response with nothing outstanding is illegal and simply ignored.
    assign respValid = imem_rvalid && (outstanding != '0);
    assign respKeep  = respValid && (discard == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypassHit = respKeep && (count == '0);
`else
    assign bypassHit = 1'b0;
`endif

    assign dec_valid   = rst && ((count != '0) || bypassHit);
    assign dec_instr   = bypassHit ? imem_rdata : instrMem[rdPtr];
    assign dec_pc      = bypassHit ? tagMem[tagRdPtr] : pcMem[rdPtr];
    assign dec_pcplus4 = dec_pc + WIDTH'(4);

    // A redirect swallows any decode handshake in the same cycle.
    assign pop  = !redirect && dec_ready && (count != '0);
    assign push = respKeep && !(bypassHit && dec_ready);

    // Control state: fetch PC, queue/tag pointers, occupancy and drop count.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetchPc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            rdPtr       <= '0;
            wrPtr       <= '0;
            tagRdPtr    <= '0;
            tagWrPtr    <= '0;
        end else begin
            // In-flight bookkeeping is independent of redirects: dropped
            // responses still return and still consume their tag.
            outstanding <= outstanding + CW'(grant) - CW'(respValid);
            if (grant)     tagWrPtr <= tagWrPtr + 1'b1;
            if (respValid) tagRdPtr <= tagRdPtr + 1'b1;

            if (redirect) begin
                fetchPc <= redirect_pc;
                count   <= '0;
                rdPtr   <= '0;
                wrPtr   <= '0;
                // Everything still in flight after this edge is stale.
                discard <= outstanding + CW'(grant) - CW'(respValid);
            end else begin
                if (grant) fetchPc <= fetchPc + WIDTH'(4);
                if (push)  wrPtr   <= wrPtr + 1'b1;
                if (pop)   rdPtr   <= rdPtr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
                if (respValid && (discard != '0)) discard <= discard - 1'b1;
            end
        end
    end

    // Storage arrays: request PC tags and queued {instruction, PC} pairs.
    // NOTE: the arrays carry no reset; occupancy and pointers decide which
    // entries are meaningful, so clearing the data would only cost flops.
    always_ff @(posedge clk) begin
        if (grant) tagMem[tagWrPtr] <= fetchPc;
        if (push) begin
            instrMem[wrPtr] <= imem_rdata;
            pcMem[wrPtr]    <= tagMem[tagRdPtr];
        end
    end

`ifndef SYNTHESIS
    // Memory must never answer a request that was not issued.
    rvalidNeedsRequest: assert property (@(posedge clk) disable iff (!rst)
        imem_rvalid |-> (outstanding != '0));
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a variable-latency memory model plus
// a queue-level reference of which PCs decode must see and in what order.
module tb_fetch_queue;
    localparam int          WIDTH    = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_pcplus4;
    logic        dec_ready;

    always #5 clk = ~clk;

    fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc),
        .dec_pcplus4(dec_pcplus4), .dec_ready(dec_ready)
    );

    int checks = 0;
    int errors = 0;

    // One request in flight: address, cycle its response is due, and whether
    // it is still wanted (cleared by a later redirect).
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          live;
    } flightT;

    flightT      flight[$];
    logic [31:0] modelQ[$];   // PCs buffered for decode, oldest first
    logic [31:0] popped[$];   // PCs decode accepted, in order
    logic [31:0] expPc;
    int          cyc;
    int          grants;

    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
    endfunction

    task automatic clear_model();
        flight.delete();
        modelQ.delete();
        popped.delete();
        expPc  = RESET_PC;
        cyc    = 0;
        grants = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; dec_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clear_model();
    endtask

    // One clock of stimulus: drive inputs at the falling edge, compare the
    // settled outputs against the reference, then advance the reference.
    task automatic run_cycle(input bit doRedir, input logic [31:0] rpc,
                             input bit gnt, input bit rdy,
                             input int latMin, input int latMax);
        bit          rv, expReq, expValid, byp, consumedByp, live;
        logic [31:0] head, respAddr;
        int          qSize, due;
        flightT      f;
        @(negedge clk);
        rv = (flight.size() > 0) && (flight[0].due <= cyc);
        redirect = doRedir; redirect_pc = rpc; imem_gnt = gnt; dec_ready = rdy;
        imem_rvalid = rv;
        imem_rdata  = rv ? instrOf(flight[0].addr) : 32'hDEAD_BEEF;
        #1;
        qSize = modelQ.size();
        live  = rv && flight[0].live;
        byp   = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = (qSize == 0) && live;
`endif
        expReq   = !doRedir && ((qSize + flight.size()) < DEPTH);
        expValid = (qSize != 0) || byp;
        head     = (qSize != 0) ? modelQ[0] : (rv ? flight[0].addr : 32'h0);

        checks++;
        if (imem_req !== expReq) begin
            errors++;
            $display("FAIL imem_req cyc=%0d: got %b expected %b", cyc, imem_req, expReq);
        end
        checks++;
        if (imem_addr !== expPc) begin
            errors++;
            $display("FAIL imem_addr cyc=%0d: got %h expected %h", cyc, imem_addr, expPc);
        end
        checks++;
        if (dec_valid !== expValid) begin
            errors++;
            $display("FAIL dec_valid cyc=%0d: got %b expected %b", cyc, dec_valid, expValid);
        end
        if (expValid) begin
            checks++;
            if (dec_pc !== head) begin
                errors++;
                $display("FAIL dec_pc cyc=%0d: got %h expected %h", cyc, dec_pc, head);
            end
            checks++;
            if (dec_instr !== instrOf(head)) begin
                errors++;
                $display("FAIL dec_instr cyc=%0d: got %h expected %h", cyc, dec_instr, instrOf(head));
            end
            checks++;
            if (dec_pcplus4 !== head + 32'd4) begin
                errors++;
                $display("FAIL dec_pcplus4 cyc=%0d: got %h expected %h", cyc, dec_pcplus4, head + 32'd4);
            end
        end

        if (imem_req && gnt) grants++;

        // Decode handshake (ignored under redirect).
        consumedByp = 1'b0;
        if (!doRedir && rdy && expValid) begin
            popped.push_back(head);
            if (qSize != 0) void'(modelQ.pop_front());
            else consumedByp = 1'b1;
        end
        // Memory response: wanted ones join the decode queue.
        if (rv) begin
            f = flight.pop_front();
            respAddr = f.addr;
            if (f.live && !consumedByp) modelQ.push_back(respAddr);
        end
        // New request, kept in order behind older ones.
        if (expReq && gnt) begin
            due = cyc + $urandom_range(latMin, latMax);
            if (flight.size() > 0 && flight[$].due > due) due = flight[$].due;
            flight.push_back('{addr: expPc, due: due, live: 1'b1});
            expPc = expPc + 32'd4;
        end
        if (doRedir) begin
            modelQ.delete();
            foreach (flight[i]) flight[i].live = 1'b0;
            expPc = rpc;
        end
        cyc++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; dec_ready = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL reset_req: got %b expected 0", imem_req);
        end
        checks++;
        if (dec_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", dec_valid);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clear_model();
        #1;
        checks++;
        if (imem_addr !== RESET_PC) begin
            errors++; $display("FAIL reset_addr: got %h expected %h", imem_addr, RESET_PC);
        end
        checks++;
        if (imem_req !== 1'b1) begin
            errors++; $display("FAIL reset_release_req: got %b expected 1", imem_req);
        end
    endtask

    // Single response into an empty queue: 1-cycle fill latency by default,
    // same-cycle forwarding when the bypass is built in.
    task automatic test_fill_latency();
        do_reset();
        @(negedge clk);
        imem_gnt = 1'b1; dec_ready = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            errors++; $display("FAIL fill_req: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RESET_PC);
        end
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        checks++;
        if (dec_valid !== 1'b1 || dec_instr !== 32'h0050_0093 || dec_pc !== RESET_PC) begin
            errors++; $display("FAIL bypass_same_cycle: got v=%b i=%h pc=%h expected v=1 i=00500093 pc=%h", dec_valid, dec_instr, dec_pc, RESET_PC);
        end
`else
        checks++;
        if (dec_valid !== 1'b0) begin
            errors++; $display("FAIL fill_same_cycle: got %b expected 0", dec_valid);
        end
`endif
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        checks++;
        if (dec_valid !== 1'b0) begin
            errors++; $display("FAIL bypass_not_written: got %b expected 0", dec_valid);
        end
`else
        checks++;
        if (dec_valid !== 1'b1 || dec_instr !== 32'h0050_0093 || dec_pc !== RESET_PC) begin
            errors++; $display("FAIL fill_next_cycle: got v=%b i=%h pc=%h expected v=1 i=00500093 pc=%h", dec_valid, dec_instr, dec_pc, RESET_PC);
        end
        @(negedge clk);
        #1;
        checks++;
        if (dec_valid !== 1'b0) begin
            errors++; $display("FAIL fill_popped: got %b expected 0", dec_valid);
        end
`endif
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 20; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1, 1);
        checks++;
        if (grants != 20) begin
            errors++; $display("FAIL stream_grants: got %0d expected 20", grants);
        end
        checks++;
        if (popped.size() < 15) begin
            errors++; $display("FAIL stream_pops: got %0d expected at least 15", popped.size());
        end
        foreach (popped[i]) begin
            checks++;
            if (popped[i] !== 32'(i * 4)) begin
                errors++; $display("FAIL stream_order[%0d]: got %h expected %h", i, popped[i], 32'(i * 4));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b0, 1, 1);
        checks++;
        if (grants != DEPTH) begin
            errors++; $display("FAIL stall_grants: got %0d expected %0d", grants, DEPTH);
        end
        checks++;
        if (imem_req !== 1'b0 || dec_valid !== 1'b1) begin
            errors++; $display("FAIL stall_full: got req=%b valid=%b expected req=0 valid=1", imem_req, dec_valid);
        end
        for (int i = 0; i < 8; i++) run_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1, 1);
        checks++;
        if (popped.size() != DEPTH) begin
            errors++; $display("FAIL stall_drain: got %0d pops expected %0d", popped.size(), DEPTH);
        end
        foreach (popped[i]) begin
            checks++;
            if (popped[i] !== 32'(i * 4)) begin
                errors++; $display("FAIL stall_order[%0d]: got %h expected %h", i, popped[i], 32'(i * 4));
            end
        end
    endtask

    task automatic check_redirect_stream(input string name, input logic [31:0] target);
        checks++;
        if (popped.size() == 0) begin
            errors++; $display("FAIL %s: got no instruction expected first pc %h", name, target);
        end
        foreach (popped[i]) begin
            checks++;
            if (popped[i] !== target + 32'(i * 4)) begin
                errors++; $display("FAIL %s[%0d]: got %h expected %h", name, i, popped[i], target + 32'(i * 4));
            end
        end
    endtask

    task automatic test_redirect_flush();
        do_reset();
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b0, 5, 5);
        run_cycle(1'b1, 32'h100, 1'b1, 1'b0, 1, 1);
        for (int i = 0; i < 15; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1, 1);
        check_redirect_stream("flush_order", 32'h100);
    endtask

    // Redirect lands in the same cycle as a response with two outstanding.
    task automatic test_redirect_rvalid();
        do_reset();
        run_cycle(1'b0, 32'h0, 1'b1, 1'b0, 4, 4);
        run_cycle(1'b0, 32'h0, 1'b1, 1'b0, 4, 4);
        run_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1, 1);
        run_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1, 1);
        run_cycle(1'b1, 32'h100, 1'b1, 1'b1, 1, 1);
        for (int i = 0; i < 12; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1, 1);
        check_redirect_stream("rvalid_redirect_order", 32'h100);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 2, 3);
        run_cycle(1'b1, 32'h200, 1'b1, 1'b1, 1, 1);
        run_cycle(1'b1, 32'h300, 1'b1, 1'b1, 1, 1);
        popped.delete();
        for (int i = 0; i < 15; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1, 2);
        check_redirect_stream("back_to_back_order", 32'h300);
    endtask

    task automatic test_async_reset();
        do_reset();
        run_cycle(1'b0, 32'h0, 1'b1, 1'b0, 5, 5);
        run_cycle(1'b0, 32'h0, 1'b1, 1'b0, 5, 5);
        @(negedge clk);
        imem_rvalid = 1'b0; imem_gnt = 1'b1; redirect = 1'b0; dec_ready = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || dec_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset: got req=%b valid=%b expected 0 0", imem_req, dec_valid);
        end
        repeat (2) @(negedge clk);
        imem_gnt = 1'b0;
        rst = 1'b1;
        clear_model();
        #1;
        checks++;
        if (imem_addr !== RESET_PC || dec_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset_release: got addr=%h valid=%b expected %h 0", imem_addr, dec_valid, RESET_PC);
        end
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1, 2);
    endtask

    task automatic test_random();
        bit          r;
        logic [31:0] rpc;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            r   = ($urandom_range(0, 19) == 0);
            rpc = 32'($urandom_range(0, 1023)) << 2;
            run_cycle(r, rpc, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 1, 6);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; dec_ready = 1'b0;
        clear_model();
        test_reset();
        test_fill_latency();
        test_stream();
        test_stall();
        test_redirect_flush();
        test_redirect_rvalid();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
